// File: rtl/xentry_pkg.sv
// Shared types for the xentry dcache: memory operations,
// controller states and the watchdog-disable sentinel.
package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } dcache_state_e;

  localparam int unsigned DCACHE_WATCHDOG_DISABLED = 0;

endpackage

// File: rtl/l2_watchdog.sv
// L2 beat watchdog: counts stalled cycles, flags expiry.
// Ports: clear_i/stall_i in; expire_o (comb), timeout_o (sticky).
module l2_watchdog
  import xentry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic stall_i,
  output logic expire_o,
  output logic timeout_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT =
    TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] count_q, count_d, count_inc;
  logic                 err_q, err_d;

  // Expire on the stall that brings the count to LIMIT.
  always_comb begin
    count_inc = count_q + TIMEOUT_W'(1);
    expire_o  = stall_i && (count_inc == LIMIT);
    count_d   = count_q;
    if (clear_i)
      count_d = '0;
    else if (stall_i)
      count_d = count_inc;
    err_d = err_q | expire_o;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign timeout_o = err_q;

endmodule

// File: rtl/dcache_controller.sv
// Dcache control FSM: hit, writeback, fill, CLFLUSH sequencing.
// Ports: pipeline req/fulfil, datapath flags/strobes, L2 handshake.
module dcache_controller
  import xentry_pkg::*;
#(
  parameter int unsigned L2_TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pipe_req_valid,
  input  memory_operation_e pipe_req_type,
  output logic              pipe_req_fulfilled,
  input  logic              hit,
  input  logic              miss,
  input  logic              valid_dirty_bit,
  input  logic              clflush_requested,
  input  logic              counter_done,
  output logic              flush_mode,
  output logic              load_mode,
  output logic              clear_selected_dirty_bit,
  output logic              clear_selected_valid_bit,
  output logic              finish_new_line_install,
  output logic              set_new_l2_block_address,
  output logic              use_dirty_tag_for_l2_block_address,
  output logic              reset_counter,
  output logic              decrement_counter,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  input  logic              l2_req_fulfilled,
  output logic              l2_timeout
);

  dcache_state_e state_q, state_d;
  logic          flush_origin_q, flush_origin_d;
  logic          wd_expire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      flush_origin_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_origin_q <= flush_origin_d;
    end
  end

  always_comb begin
    state_d                            = state_q;
    flush_origin_d                     = flush_origin_q;
    pipe_req_fulfilled                 = 1'b0;
    flush_mode                         = 1'b0;
    load_mode                          = 1'b0;
    clear_selected_dirty_bit           = 1'b0;
    clear_selected_valid_bit           = 1'b0;
    finish_new_line_install            = 1'b0;
    set_new_l2_block_address           = 1'b0;
    use_dirty_tag_for_l2_block_address = 1'b0;
    reset_counter                      = 1'b0;
    decrement_counter                  = 1'b0;
    l2_req_valid                       = 1'b0;
    l2_req_type                        = LOAD;
    unique case (state_q)
      IDLE: begin
        if (pipe_req_valid) begin
          if (clflush_requested && valid_dirty_bit) begin
            set_new_l2_block_address           = 1'b1;
            use_dirty_tag_for_l2_block_address = 1'b1;
            reset_counter                      = 1'b1;
            flush_origin_d                     = 1'b1;
            state_d                            = WRITEBACK;
          end else if (clflush_requested) begin
            clear_selected_valid_bit = 1'b1;
            pipe_req_fulfilled       = 1'b1;
          end else if (hit) begin
            pipe_req_fulfilled = 1'b1;
          end else if (miss && valid_dirty_bit) begin
            set_new_l2_block_address           = 1'b1;
            use_dirty_tag_for_l2_block_address = 1'b1;
            reset_counter                      = 1'b1;
            flush_origin_d                     = 1'b0;
            state_d                            = WRITEBACK;
          end else if (miss) begin
            set_new_l2_block_address = 1'b1;
            reset_counter            = 1'b1;
            state_d                  = FETCH;
          end
        end
      end
      WRITEBACK: begin
        flush_mode   = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_type  = STORE;
        if (l2_req_fulfilled) begin
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            clear_selected_dirty_bit = 1'b1;
            if (flush_origin_q) begin
              clear_selected_valid_bit = 1'b1;
              pipe_req_fulfilled       = 1'b1;
              state_d                  = IDLE;
            end else begin
              set_new_l2_block_address = 1'b1;
              reset_counter            = 1'b1;
              state_d                  = FETCH;
            end
          end
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        load_mode    = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_type  = LOAD;
        if (l2_req_fulfilled) begin
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            finish_new_line_install = 1'b1;
            state_d                 = IDLE;
          end
        end else if (wd_expire) begin
          // Partial fill: drop the line so the retry misses cleanly.
          clear_selected_valid_bit = 1'b1;
          state_d                  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if (L2_TIMEOUT_CYCLES != DCACHE_WATCHDOG_DISABLED) begin : g_wd
    l2_watchdog #(
      .TIMEOUT_CYCLES(L2_TIMEOUT_CYCLES),
      .TIMEOUT_W     (TIMEOUT_W)
    ) u_wd (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (reset_counter | l2_req_fulfilled),
      .stall_i  (l2_req_valid & ~l2_req_fulfilled),
      .expire_o (wd_expire),
      .timeout_o(l2_timeout)
    );
  end else begin : g_no_wd
    assign wd_expire  = 1'b0;
    assign l2_timeout = 1'b0;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(hit && miss))
        else $error("hit and miss both set");
      if (state_q != IDLE)
        assert (pipe_req_valid)
          else $error("request dropped mid-refill");
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a datapath/L2 model.
// Expected L2 beats and completions are queued, popped on output.
module tb_dcache_controller;
  import xentry_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              pipe_req_valid;
  memory_operation_e pipe_req_type;
  logic              pipe_req_fulfilled;
  logic              hit, miss, valid_dirty_bit;
  logic              clflush_requested, counter_done;
  logic              flush_mode, load_mode;
  logic              clr_dirty, clr_valid, finish;
  logic              set_new, use_dirty;
  logic              reset_counter, decrement_counter;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic              l2_req_fulfilled;
  logic              l2_timeout;

  dcache_controller #(
    .L2_TIMEOUT_CYCLES(4),
    .TIMEOUT_W        (16)
  ) dut (
    .clk                               (clk),
    .reset_n                           (reset_n),
    .pipe_req_valid                    (pipe_req_valid),
    .pipe_req_type                     (pipe_req_type),
    .pipe_req_fulfilled                (pipe_req_fulfilled),
    .hit                               (hit),
    .miss                              (miss),
    .valid_dirty_bit                   (valid_dirty_bit),
    .clflush_requested                 (clflush_requested),
    .counter_done                      (counter_done),
    .flush_mode                        (flush_mode),
    .load_mode                         (load_mode),
    .clear_selected_dirty_bit          (clr_dirty),
    .clear_selected_valid_bit          (clr_valid),
    .finish_new_line_install           (finish),
    .set_new_l2_block_address          (set_new),
    .use_dirty_tag_for_l2_block_address(use_dirty),
    .reset_counter                     (reset_counter),
    .decrement_counter                 (decrement_counter),
    .l2_req_valid                      (l2_req_valid),
    .l2_req_type                       (l2_req_type),
    .l2_req_fulfilled                  (l2_req_fulfilled),
    .l2_timeout                        (l2_timeout)
  );

  wire [12:0] outs = {pipe_req_fulfilled, flush_mode,
    load_mode, clr_dirty, clr_valid, finish, set_new,
    use_dirty, reset_counter, decrement_counter,
    l2_req_valid, l2_req_type};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // datapath + L2 model
  logic       lv, ld;
  logic [7:0] ltag, rtag, l2tag;
  logic [2:0] cnt;
  int         wcnt, gap, cyc, start_cyc;
  logic       pl_en, pl_v, pl_d;
  logic [7:0] pl_tag;

  wire resident = lv && (ltag == rtag);
  wire is_fl = pipe_req_valid && pipe_req_type == CLFLUSH;
  wire is_rw = pipe_req_valid && pipe_req_type != CLFLUSH;
  assign hit               = is_rw && resident;
  assign miss              = is_rw && !resident;
  assign clflush_requested = is_fl;
  assign valid_dirty_bit   = lv && ld;
  assign counter_done      = (cnt == 3'd0);
  assign l2_req_fulfilled  = reset_n && l2_req_valid &&
    ((gap == 0) ? l2_timeout : (wcnt == gap - 1));

  initial begin
    cyc  = 0;
    wcnt = 0;
    cnt  = 3'd0;
    lv   = 1'b0;
    ld   = 1'b0;
    ltag = 8'd0;
    l2tag = 8'd0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!l2_req_valid || l2_req_fulfilled) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (reset_counter) cnt <= 3'd7;
    else if (decrement_counter) cnt <= cnt - 3'd1;
    if (set_new) l2tag <= use_dirty ? ltag : rtag;
    if (pl_en) begin
      lv   <= pl_v;
      ld   <= pl_d;
      ltag <= pl_tag;
    end else begin
      if (clr_dirty) ld <= 1'b0;
      if (clr_valid) lv <= 1'b0;
      if (finish) begin
        lv   <= 1'b1;
        ld   <= 1'b0;
        ltag <= rtag;
      end
      if (hit && pipe_req_fulfilled &&
          pipe_req_type == STORE)
        ld <= 1'b1;
    end
  end

  typedef struct {
    memory_operation_e op;
    logic [2:0]        word;
    logic [7:0]        tag;
    logic              last;
  } beat_t;

  typedef struct {
    int   lat;
    logic clrv;
    logic l2v;
  } done_t;

  beat_t bq[$];
  done_t dq[$];
  beat_t mb;
  done_t md;

  always @(negedge clk) begin
    if (reset_n) begin
      if (l2_req_valid && !l2_req_fulfilled)
        chk("stall_dec", decrement_counter, 0);
      if (l2_req_valid && l2_req_fulfilled) begin
        if (bq.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          mb = bq.pop_front();
          chk("beat_op", l2_req_type, mb.op);
          chk("beat_word", cnt, mb.word);
          chk("beat_tag", l2tag, mb.tag);
          chk("beat_dec", decrement_counter, !mb.last);
          chk("beat_fin", finish,
              mb.last && mb.op == LOAD);
          chk("beat_cdirty", clr_dirty,
              mb.last && mb.op == STORE);
        end
      end
      if (pipe_req_fulfilled) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          md = dq.pop_front();
          chk("done_lat", cyc - start_cyc + 1, md.lat);
          chk("done_clrv", clr_valid, md.clrv);
          chk("done_l2v", l2_req_valid, md.l2v);
        end
      end
    end
  end

  task automatic preload(input logic v, input logic d,
                         input logic [7:0] t);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_v = v; pl_d = d; pl_tag = t;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic start_req(
    input memory_operation_e op, input logic [7:0] tag,
    input int g, input int n_wb, input logic [7:0] wtag,
    input int n_fe, input int lat, input logic clrv,
    input logic push_done);
    beat_t b;
    done_t d;
    for (int i = 0; i < n_wb; i++) begin
      b.op = STORE; b.word = 3'(7 - i);
      b.tag = wtag; b.last = (i == 7);
      bq.push_back(b);
    end
    for (int i = 0; i < n_fe; i++) begin
      b.op = LOAD; b.word = 3'(7 - i);
      b.tag = tag; b.last = (i == 7);
      bq.push_back(b);
    end
    if (push_done) begin
      d.lat  = lat;
      d.clrv = clrv;
      d.l2v  = (op == CLFLUSH) && (n_wb > 0);
      dq.push_back(d);
    end
    @(posedge clk); #1;
    gap            = g;
    rtag           = tag;
    pipe_req_type  = op;
    pipe_req_valid = 1'b1;
    start_cyc      = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!pipe_req_fulfilled && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!pipe_req_fulfilled) chk("wait_done", 0, 1);
    @(posedge clk); #1;
    pipe_req_valid = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    pipe_req_valid = 1'b0;
    pipe_req_type  = LOAD;
    pl_en = 1'b0; pl_v = 1'b0; pl_d = 1'b0;
    pl_tag = 8'd0; rtag = 8'd0;
    gap = 1; start_cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'(outs), 0);
    chk("rst_timeout", l2_timeout, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: load hit
    preload(1'b1, 1'b0, 8'h11);
    start_req(LOAD, 8'h11, 1, 0, 8'h0, 0, 1, 0, 1);
    wait_done();

    // 2: store clean miss, L2 every cycle
    preload(1'b0, 1'b0, 8'h00);
    start_req(STORE, 8'h22, 1, 0, 8'h0, 8, 10, 0, 1);
    wait_done();
    chk("store_dirty", ld, 1);
    chk("store_tag", ltag, 8'h22);

    // 3: load miss on dirty line, L2 every 3rd cycle
    preload(1'b1, 1'b1, 8'h33);
    start_req(LOAD, 8'h44, 3, 8, 8'h33, 8, 50, 0, 1);
    wait_done();
    chk("wb_fill_valid", lv, 1);
    chk("wb_fill_dirty", ld, 0);

    // 4: clflush dirty then clean
    preload(1'b1, 1'b1, 8'h55);
    start_req(CLFLUSH, 8'h55, 1, 8, 8'h55, 0, 9, 1, 1);
    wait_done();
    chk("fl_dirty_valid", lv, 0);
    preload(1'b1, 1'b0, 8'h66);
    start_req(CLFLUSH, 8'h66, 1, 0, 8'h0, 0, 1, 1, 1);
    wait_done();
    chk("fl_clean_valid", lv, 0);

    // 5: L2 silent until watchdog fires, then retry
    preload(1'b0, 1'b0, 8'h00);
    start_req(LOAD, 8'h77, 0, 0, 8'h0, 8, 15, 0, 1);
    @(negedge clk);
    chk("wd_miss", set_new, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wd_l2v", l2_req_valid, 1);
      chk("wd_clrv", clr_valid, (i == 3));
      chk("wd_to_pre", l2_timeout, 0);
      chk("wd_nofulfil", pipe_req_fulfilled, 0);
    end
    @(negedge clk);
    chk("wd_to_post", l2_timeout, 1);
    chk("wd_idle", l2_req_valid, 0);
    chk("wd_retry", set_new, 1);
    wait_done();

    // 6: reset during fill, on beat 3
    preload(1'b0, 1'b0, 8'h00);
    chk("sticky_timeout", l2_timeout, 1);
    start_req(LOAD, 8'h88, 1, 0, 8'h0, 3, 0, 0, 0);
    for (int n = 0; n < 50 && bq.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    chk("mid_beats", bq.size(), 0);
    @(posedge clk); #1;
    reset_n        = 1'b0;
    pipe_req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", 32'(outs), 0);
    chk("mid_rst_timeout", l2_timeout, 0);

    chk("sb_beats_left", bq.size(), 0);
    chk("sb_done_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
